// File: rtl/readyvalid_sink_checker_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_stream_pkg : shared types/constants for the ready/valid stream checker  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package rv_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } rv_sink_state_e;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Increment that sticks at the all-ones value of a WIDTH-bit counter
  function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input int unsigned width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    return (cnt >= max_v) ? cnt : cnt + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/readyvalid_sink_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | readyvalid_sink_checker_if : ready/valid stream bundle                     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface readyvalid_sink_checker_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/readyvalid_sink_checker_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_lfsr16 : 16-bit Galois LFSR, advances every cycle, reset to seed        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rv_lfsr16
  import rv_stream_pkg::*;
(
  input  wire         clk,
  input  wire         rst_n,
  input  wire  [15:0] seed,
  output logic [15:0] out
);
  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= seed;
    end else begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign out = r_lfsr;
endmodule
`default_nettype wire

// File: rtl/readyvalid_sink_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | readyvalid_sink_checker : stream sink that checks an incrementing pattern  |
// | Optional LFSR backpressure when RV_SINK_LFSR_READY_EN is defined.          |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module readyvalid_sink_checker
  import rv_stream_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  wire                        clk,
  input  wire                        rst_n,
  input  wire                        sink_enable,
  readyvalid_sink_checker_if.slave   s_in,
  output logic                       captured_data_valid,
  output logic [WIDTH-1:0]           captured_data,
  output logic [CNT_W-1:0]           rx_count,
  output logic [CNT_W-1:0]           err_count,
  output logic                       locked,
  output logic                       mismatch
);

  rv_sink_state_e   r_state;
  logic [WIDTH-1:0] r_expected;
  logic             r_locked;
  logic             r_cap_valid;
  logic [WIDTH-1:0] r_cap_data;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_rx_count;
  logic [CNT_W-1:0] r_err_count;

  logic             w_lfsr_gate;
  logic             w_in_ready;
  logic             w_accept;

  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

`ifdef RV_SINK_LFSR_READY_EN
  logic [15:0] w_lfsr;

  rv_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .out   (w_lfsr)
  );

  assign w_lfsr_gate = (w_lfsr[1:0] != 2'b00);
`else
  assign w_lfsr_gate = 1'b1;
`endif

  // Ready never looks at in_valid, so the source can't form a combinational loop
  assign w_in_ready      = (r_state != IDLE) && sink_enable && w_lfsr_gate;
  assign w_accept        = s_in.in_valid && w_in_ready;
  assign s_in.in_ready   = w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_expected  <= '0;
      r_locked    <= 1'b0;
      r_cap_valid <= 1'b0;
      r_cap_data  <= '0;
      r_mismatch  <= 1'b0;
      r_rx_count  <= '0;
      r_err_count <= '0;
    end else begin
      r_cap_valid <= w_accept;
      r_mismatch  <= 1'b0;
      if (w_accept) begin
        r_cap_data <= s_in.in_data;
        r_rx_count <= CNT_W'(sat_inc(64'(r_rx_count), CNT_W));
      end

      case (r_state)
        IDLE: begin
          if (sink_enable) begin
            r_state <= r_locked ? CHECK : SYNC;
          end
        end
        SYNC: begin
          if (!sink_enable) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            r_expected <= s_in.in_data + WIDTH'(1);
            r_locked   <= 1'b1;
            r_state    <= CHECK;
          end
        end
        CHECK: begin
          if (!sink_enable) begin
            r_state <= IDLE;
          end else if (w_accept) begin
            // Always re-seed from the received beat so one bad beat costs one error
            r_expected <= s_in.in_data + WIDTH'(1);
            if (s_in.in_data !== r_expected) begin
              r_mismatch  <= 1'b1;
              r_err_count <= CNT_W'(sat_inc(64'(r_err_count), CNT_W));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign captured_data_valid = r_cap_valid;
  assign captured_data       = r_cap_data;
  assign rx_count            = r_rx_count;
  assign err_count           = r_err_count;
  assign locked              = r_locked;
  assign mismatch            = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_readyvalid_sink_checker.sv
`default_nettype none
// Directed bench: two checker instances (CNT_W=16 and CNT_W=4) driven by one stream.
module tb_readyvalid_sink_checker;

  logic clk;
  logic rst_n;
  logic sink_enable;
  int   checks;
  int   errors;

  readyvalid_sink_checker_if #(.WIDTH(8)) s16 ();
  readyvalid_sink_checker_if #(.WIDTH(8)) s4 ();

  assign s4.in_valid = s16.in_valid;
  assign s4.in_data  = s16.in_data;

  logic        cdv16, lk16, mis16;
  logic [7:0]  cd16;
  logic [15:0] rx16, err16;
  logic        cdv4, lk4, mis4;
  logic [7:0]  cd4;
  logic [3:0]  rx4, err4;

  readyvalid_sink_checker #(.WIDTH(8), .CNT_W(16), .LFSR_SEED(16'hACE1)) dut16 (
    .clk (clk), .rst_n (rst_n), .sink_enable (sink_enable), .s_in (s16.slave),
    .captured_data_valid (cdv16), .captured_data (cd16), .rx_count (rx16),
    .err_count (err16), .locked (lk16), .mismatch (mis16)
  );

  readyvalid_sink_checker #(.WIDTH(8), .CNT_W(4), .LFSR_SEED(16'hACE1)) dut4 (
    .clk (clk), .rst_n (rst_n), .sink_enable (sink_enable), .s_in (s4.slave),
    .captured_data_valid (cdv4), .captured_data (cd4), .rx_count (rx4),
    .err_count (err4), .locked (lk4), .mismatch (mis4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          grp;
    logic [7:0]  data;
    logic        mis;
    logic [15:0] rx;
    logic [15:0] err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sink_enable  = 1'b0;
    s16.in_valid = 1'b0;
    s16.in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n       = 1'b1;
    sink_enable = 1'b1;
    @(negedge clk);
  endtask

  // Called just after a negedge; returns just after the following negedge
  task automatic send_beat(input logic [7:0] d, input logic exp_mis,
                           input logic [15:0] exp_rx, input logic [15:0] exp_err);
    int n;
    s16.in_valid = 1'b1;
    s16.in_data  = d;
    #1;
    n = 0;
    while (!s16.in_ready && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: got no in_ready, expected in_ready=1 for data 0x%0h", d);
      s16.in_valid = 1'b0;
      @(negedge clk);
    end else begin
      @(posedge clk);
      #1;
      chk("cap_valid", 64'(cdv16), 64'd1);
      chk("cap_data", 64'(cd16), 64'(d));
      chk("mismatch", 64'(mis16), 64'(exp_mis));
      chk("rx_count", 64'(rx16), 64'(exp_rx));
      chk("err_count", 64'(err16), 64'(exp_err));
      chk("locked", 64'(lk16), 64'd1);
      @(negedge clk);
      s16.in_valid = 1'b0;
    end
  endtask

  initial begin
    int ready_cnt;
    checks = 0;
    errors = 0;

    vecs[0]  = '{0, 8'h05, 1'b0, 16'd1, 16'd0};
    vecs[1]  = '{0, 8'h06, 1'b0, 16'd2, 16'd0};
    vecs[2]  = '{0, 8'h07, 1'b0, 16'd3, 16'd0};
    vecs[3]  = '{0, 8'h08, 1'b0, 16'd4, 16'd0};
    vecs[4]  = '{1, 8'hFE, 1'b0, 16'd1, 16'd0};
    vecs[5]  = '{1, 8'hFF, 1'b0, 16'd2, 16'd0};
    vecs[6]  = '{1, 8'h00, 1'b0, 16'd3, 16'd0};
    vecs[7]  = '{1, 8'h01, 1'b0, 16'd4, 16'd0};
    vecs[8]  = '{2, 8'h10, 1'b0, 16'd1, 16'd0};
    vecs[9]  = '{2, 8'h11, 1'b0, 16'd2, 16'd0};
    vecs[10] = '{2, 8'h13, 1'b1, 16'd3, 16'd1};
    vecs[11] = '{2, 8'h14, 1'b0, 16'd4, 16'd1};

    // Reset held with a valid beat offered
    rst_n        = 1'b0;
    sink_enable  = 1'b1;
    s16.in_valid = 1'b1;
    s16.in_data  = 8'h5A;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(s16.in_ready), 64'd0);
    chk("rst_cap_valid", 64'(cdv16), 64'd0);
    chk("rst_cap_data", 64'(cd16), 64'd0);
    chk("rst_rx", 64'(rx16), 64'd0);
    chk("rst_err", 64'(err16), 64'd0);
    chk("rst_locked", 64'(lk16), 64'd0);
    chk("rst_mismatch", 64'(mis16), 64'd0);

    for (int i = 0; i < 12; i++) begin
      if (i == 0 || vecs[i].grp != vecs[i-1].grp) do_reset();
      send_beat(vecs[i].data, vecs[i].mis, vecs[i].rx, vecs[i].err);
    end
    chk("pc4_rx_after_mismatch_grp", 64'(rx4), 64'd4);

    // Pause: ready must stay low, nothing accepted, lock retained
    sink_enable  = 1'b0;
    s16.in_valid = 1'b1;
    s16.in_data  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("pause_in_ready", 64'(s16.in_ready), 64'd0);
      @(negedge clk);
    end
    chk("pause_rx", 64'(rx16), 64'd4);
    chk("pause_locked", 64'(lk16), 64'd1);
    chk("pause_cap_data", 64'(cd16), 64'h14);
    chk("pause_cap_valid", 64'(cdv16), 64'd0);
    s16.in_valid = 1'b0;
    sink_enable  = 1'b1;
    send_beat(8'h15, 1'b0, 16'd5, 16'd1);
    send_beat(8'h16, 1'b0, 16'd6, 16'd1);

    // Asynchronous reset mid-stream clears immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("amid_rx", 64'(rx16), 64'd0);
    chk("amid_err", 64'(err16), 64'd0);
    chk("amid_locked", 64'(lk16), 64'd0);
    chk("amid_in_ready", 64'(s16.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_beat(8'h80, 1'b0, 16'd1, 16'd0);
    send_beat(8'h81, 1'b0, 16'd2, 16'd0);

    // Ready duty cycle over a fixed window
    do_reset();
    @(negedge clk);
    ready_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (s16.in_ready) ready_cnt++;
      @(negedge clk);
    end
`ifdef RV_SINK_LFSR_READY_EN
    chk("ready_duty_in_range", 64'(ready_cnt >= 120 && ready_cnt <= 180), 64'd1);
`else
    chk("ready_duty_full", 64'(ready_cnt), 64'd200);
`endif

    // Constant stream into a fresh checker: counters saturate on the narrow instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send_beat(8'h33, (i != 0), 16'(i + 1), 16'(i));
      chk("n4_rx_sat", 64'(rx4), 64'((i + 1 > 15) ? 15 : i + 1));
      chk("n4_err_sat", 64'(err4), 64'((i > 15) ? 15 : i));
      chk("n4_mismatch", 64'(mis4), 64'(i != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
